// File: rtl/openNoc_pkt_pkg.sv
// openNoc_pkt_pkg: packet payload layout, receive FSM states and dest-field helpers shared by the PE endpoints
// Payload layout (LSB first): tx_time[31:0], seq[47:32], src id from bit 48 (src_y*X+src_x).
// Header below the payload: dest_x in the low x_size bits, then dest_y.
package openNoc_pkt_pkg;
  localparam int TS_LSB = 0;
  localparam int TS_W = 32;
  localparam int SEQ_LSB = 32;
  localparam int SEQ_W = 16;
  localparam int SRC_LSB = 48;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} rx_state_e;
  function automatic logic [7:0] dest_x(input logic [15:0] hdr, input int xs);
    return 8'(hdr & 16'((32'd1 << xs) - 32'd1));
  endfunction
  function automatic logic [7:0] dest_y(input logic [15:0] hdr, input int xs, input int ys);
    return 8'((hdr >> xs) & 16'((32'd1 << ys) - 32'd1));
  endfunction
endpackage

// File: rtl/pe_rx_checker_if.sv
// pe_rx_checker_if: NoC->PE write channel (no backpressure)
// Signals: w_valid_pe (packet valid), w_data_pe (packet {payload, dest_y, dest_x}).
// Modports: master = NoC side (drives), slave = PE receive endpoint.
interface pe_rx_checker_if #(parameter int W = 260);
  logic w_valid_pe;
  logic [W-1:0] w_data_pe;
  modport master(output w_valid_pe, output w_data_pe);
  modport slave(input w_valid_pe, input w_data_pe);
endinterface

// File: rtl/pe_seq_table.sv
// pe_seq_table: per-source expected sequence numbers for the receive checker
// Ports: clk, rstn (async active-low), clr_i (sync clear of every entry),
//   rd_addr_i/rd_data_o (combinational read), we_i/wr_addr_i/wr_data_i (single write port).
module pe_seq_table import openNoc_pkt_pkg::*; #(
  parameter int N = 16,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [SEQ_W-1:0] rd_data_o,
  input  logic             we_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [SEQ_W-1:0] wr_data_i
);
  logic [SEQ_W-1:0] tbl_q [N];
  // ids beyond X*Y-1 (non power-of-two meshes) read as 0 and are never written
  assign rd_data_o = (32'(rd_addr_i) < N) ? tbl_q[rd_addr_i] : '0;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= '0;
    end else if (we_i && 32'(wr_addr_i) < N) begin
      tbl_q[wr_addr_i] <= wr_data_i;
    end
endmodule

// File: rtl/pe_rx_checker.sv
// pe_rx_checker: PE-side receive endpoint; checks dest and per-source seq order, counts packets, latency stats
// Ports: clk, rstn (async active-low), start (run/idle, rising edge clears stats), expected_count,
//   w_if (slave side of the NoC->PE write channel), receiveCount, error_count (saturating), done,
//   lat_sum, lat_max.
// Build option: define LATENCY_STATS_EN to build the latency accumulator; otherwise lat_sum/lat_max are 0.
module pe_rx_checker import openNoc_pkt_pkg::*; #(
  parameter int X = 4,
  parameter int Y = 4,
  parameter int x_size = 2,
  parameter int y_size = 2,
  parameter int data_width = 256,
  parameter int MY_X = 0,
  parameter int MY_Y = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] expected_count,
  pe_rx_checker_if.slave w_if,
  output logic [31:0] receiveCount,
  output logic [15:0] error_count,
  output logic        done,
  output logic [47:0] lat_sum,
  output logic [31:0] lat_max
);
  localparam int SW = x_size + y_size;
  logic [data_width-1:0] pl;
  logic [SEQ_W-1:0] seq, exp_seq;
  logic [SW-1:0] src;
  logic dest_ok, run, clr, vld, good, bad;
  rx_state_e st_q, st_d;
  logic [31:0] rc_q, rc_d;
  logic [15:0] err_q, err_d;
  logic done_q;
  assign vld = w_if.w_valid_pe;
  assign pl = w_if.w_data_pe[SW +: data_width];
  assign seq = pl[SEQ_LSB +: SEQ_W];
  assign src = pl[SRC_LSB +: SW];
  assign dest_ok = dest_x(w_if.w_data_pe[15:0], x_size) == 8'(MY_X) &&
                   dest_y(w_if.w_data_pe[15:0], x_size, y_size) == 8'(MY_Y);
  assign run = st_q == ST_RUN;
  assign clr = st_q == ST_IDLE && start;
  assign good = vld && run && dest_ok && seq == exp_seq;
  assign bad = vld && !good;
  pe_seq_table #(.N(X * Y), .AW(SW)) u_seq (
    .clk(clk), .rstn(rstn), .clr_i(clr),
    .rd_addr_i(src), .rd_data_o(exp_seq),
    // a good packet and a seq mismatch both leave the entry at seq+1
    .we_i(vld && run && dest_ok), .wr_addr_i(src), .wr_data_i(seq + 16'd1)
  );
  always_comb begin
    rc_d = (clr ? 32'd0 : rc_q) + 32'(good);
    err_d = clr ? 16'(vld) : err_q + 16'(bad && err_q != 16'hFFFF);
    // DONE is judged on the next count so done rises with the packet that completes the run
    st_d = st_q == ST_IDLE ? (start ? ST_RUN : ST_IDLE) :
           !start ? ST_IDLE :
           (st_q == ST_RUN && rc_d == expected_count) ? ST_DONE : st_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st_q <= ST_IDLE;
      rc_q <= '0;
      err_q <= '0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      rc_q <= rc_d;
      err_q <= err_d;
      done_q <= st_d == ST_DONE;
    end
  assign receiveCount = rc_q;
  assign error_count = err_q;
  assign done = done_q;
`ifdef LATENCY_STATS_EN
  logic [31:0] cyc_q, lat, lm_q;
  logic [47:0] ls_q;
  logic [48:0] sum;
  logic unused_bits;
  // cycle counter shares reset with the generator, so wrap-around subtraction gives the latency
  assign lat = cyc_q - pl[TS_LSB +: TS_W];
  assign sum = {1'b0, ls_q} + 49'(lat);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cyc_q <= '0;
      ls_q <= '0;
      lm_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (clr) begin
        ls_q <= '0;
        lm_q <= '0;
      end else if (good) begin
        ls_q <= sum[48] ? '1 : sum[47:0];
        lm_q <= lat > lm_q ? lat : lm_q;
      end
    end
  assign lat_sum = ls_q;
  assign lat_max = lm_q;
  assign unused_bits = ^pl[data_width-1:SRC_LSB+SW];
`else
  logic unused_bits;
  assign lat_sum = '0;
  assign lat_max = '0;
  assign unused_bits = ^{pl[data_width-1:SRC_LSB+SW], pl[TS_LSB +: TS_W]};
`endif
endmodule
